// File: rtl/serializador_suma_pkg.sv
// serializador_pkg: shared constants for the sum-word serializer.
//   - FSM state encoding (3-bit) and the enum built on it
//   - serial line levels
//   - default sum-word width (matches the 4-bit adder output)
package serializador_pkg;

  localparam int DEFAULT_DATA_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/serializador_suma_generador_tick.sv
// generador_tick: bit-timing down-counter for the serializer.
//   clk       system clock
//   rst       synchronous active-low reset
//   restart   hold the counter at its reload value (FSM idle)
//   tick      final cycle of the current serial bit
//   tick_next next cycle will be the final cycle of the current bit
// The counter reloads itself on every terminal count, so consecutive bits
// (and back-to-back frames) are timed without an explicit restart.
module generador_tick
  import serializador_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (restart || cnt == '0)
      cnt <= RELOAD;
    else
      cnt <= cnt - CW'(1);
  end

  assign tick      = (cnt == '0);
  // Never true for BIT_CYCLES=1: the counter then sits at zero.
  assign tick_next = (cnt == CW'(1));

endmodule

// File: rtl/serializador_suma.sv
// serializador_suma: frames each adder sum word onto one serial line
// (start bit, data LSB first, optional even parity, stop bit).
//   clk        system clock
//   rst        synchronous active-low reset
//   enb, c     sum-valid strobe and sum word from the adder
//   ready      holding register empty (combinational)
//   sout       registered serial line, idles high
//   busy       registered, high from start bit through last stop cycle
//   frame_done registered pulse in the last cycle of the stop bit
//   overrun    sticky: a word arrived while the holding register was full
//
// state  | meaning
// IDLE   | line high, waiting for a word in the holding register
// START  | sending the start bit
// DATA   | sending data bits, LSB first
// PARITY | sending even parity of the data word
// STOP   | sending the stop bit; reloads directly if another word waits
module serializador_suma
  import serializador_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [DATA_W-1:0] c,
  output logic              ready,
  output logic              sout,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  // With single-cycle bits the stop bit's only cycle is also its last.
  localparam logic DONE_ON_ENTRY = (BIT_CYCLES == 1);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              hold_valid;
  logic              par;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              tick_next;
  logic              restart;

  assign ready     = !hold_valid;
  assign restart   = (state == S_IDLE);
  assign shift_nxt = shift >> 1;

  generador_tick #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      sout       <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
      shift      <= '0;
      par        <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;

      // Capture/drop decided on the pre-edge hold_valid; a load at this
      // same edge only clears hold_valid, so the two never collide.
      if (enb) begin
        if (!hold_valid) begin
          hold       <= c;
          hold_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (hold_valid) begin
            shift      <= hold;
            par        <= ^hold;
            hold_valid <= 1'b0;
            sout       <= START_BIT;
            busy       <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            sout    <= shift[0];
            bit_cnt <= LAST_BIT;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_cnt == '0) begin
              if (PARITY_EN != 0) begin
                sout  <= par;
                state <= S_PARITY;
              end else begin
                sout       <= LINE_IDLE;
                frame_done <= DONE_ON_ENTRY;
                state      <= S_STOP;
              end
            end else begin
              shift   <= shift_nxt;
              sout    <= shift_nxt[0];
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            sout       <= LINE_IDLE;
            frame_done <= DONE_ON_ENTRY;
            state      <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (hold_valid) begin
              shift      <= hold;
              par        <= ^hold;
              hold_valid <= 1'b0;
              sout       <= START_BIT;
              state      <= S_START;
            end else begin
              sout  <= LINE_IDLE;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (tick_next) begin
            frame_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializador_suma.sv
// Bench for serializador_suma: two instances (defaults, and BIT_CYCLES=3 with
// no parity) checked every cycle against a frame-position model, plus
// literal waveforms for the directed scenarios.
module tb_serializador_suma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b0;
  logic       enb0 = 1'b0;
  logic       enb1 = 1'b0;
  logic [3:0] c0   = '0;
  logic [3:0] c1   = '0;
  logic ready0, sout0, busy0, done0, ovr0;
  logic ready1, sout1, busy1, done1, ovr1;

  serializador_suma u_dut0 (
    .clk(clk), .rst(rst), .enb(enb0), .c(c0), .ready(ready0), .sout(sout0),
    .busy(busy0), .frame_done(done0), .overrun(ovr0)
  );

  serializador_suma #(.DATA_W(4), .BIT_CYCLES(3), .PARITY_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .enb(enb1), .c(c1), .ready(ready1), .sout(sout1),
    .busy(busy1), .frame_done(done1), .overrun(ovr1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: a frame is a position counter over (2+4+pe)*bc cycles; the line
  // value is derived from which bit slot the position falls in.
  bit         m_active [2];
  logic [3:0] m_word   [2];
  logic [3:0] m_hold   [2];
  int         m_pos    [2];
  bit         m_hv     [2];
  bit         m_ovr    [2];
  bit         m_sout   [2];
  bit         m_busy   [2];
  bit         m_done   [2];
  bit         m_started = 1'b0;

  task automatic model_step(input int k, input int bc, input int pe,
                            input logic r, input logic e, input logic [3:0] cw);
    int len;
    int b;
    bit hv_pre;
    len = (2 + 4 + pe) * bc;
    if (!r) begin
      m_active[k] = 0; m_pos[k] = 0; m_hv[k] = 0; m_ovr[k] = 0;
    end else begin
      hv_pre = m_hv[k];
      if (!m_active[k] || m_pos[k] == len - 1) begin
        if (hv_pre) begin
          m_active[k] = 1; m_word[k] = m_hold[k]; m_pos[k] = 0; m_hv[k] = 0;
        end else begin
          m_active[k] = 0;
        end
      end else begin
        m_pos[k]++;
      end
      if (e) begin
        if (!hv_pre) begin m_hold[k] = cw; m_hv[k] = 1; end
        else m_ovr[k] = 1;
      end
    end
    if (m_active[k]) begin
      b = m_pos[k] / bc;
      if (b == 0) m_sout[k] = 0;
      else if (b <= 4) m_sout[k] = m_word[k][b-1];
      else if (pe != 0 && b == 5) m_sout[k] = ^m_word[k];
      else m_sout[k] = 1;
      m_busy[k] = 1;
      m_done[k] = (m_pos[k] == len - 1);
    end else begin
      m_sout[k] = 1; m_busy[k] = 0; m_done[k] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, 1, 1, rst, enb0, c0);
    model_step(1, 3, 0, rst, enb1, c1);
    m_started = 1'b1;
  end

  initial forever begin
    logic [4:0] got;
    logic [4:0] exp;
    @(negedge clk);
    if (m_started) begin
      for (int k = 0; k < 2; k++) begin
        got = (k == 0) ? {sout0, busy0, done0, ready0, ovr0}
                       : {sout1, busy1, done1, ready1, ovr1};
        exp = {m_sout[k], m_busy[k], m_done[k], !m_hv[k], m_ovr[k]};
        check($sformatf("cycle dut%0d {sout,busy,done,ready,ovr}", k), 32'(got), 32'(exp));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drive a per-cycle table into instance 0; sample i is taken after the
  // edge that consumed drive i.
  task automatic play0(input int n, input logic [31:0] en_pat, input logic [127:0] c_pat,
                       output logic [31:0] s, output logic [31:0] d,
                       output logic [31:0] b, output logic [31:0] o,
                       output logic [31:0] ms);
    s = '0; d = '0; b = '0; o = '0; ms = '0;
    for (int i = 0; i < n; i++) begin
      enb0 = en_pat[i];
      c0   = c_pat[4*i +: 4];
      step();
      s[i] = sout0; d[i] = done0; b[i] = busy0; o[i] = ovr0; ms[i] = m_sout[0];
    end
    enb0 = 1'b0;
  endtask

  logic [31:0] s, d, b, o, ms;

  initial begin
    // Reset for two edges, then idle.
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset idle dut0", 32'({sout0, busy0, done0, ready0, ovr0}), 32'(5'b10010));
      check("reset idle dut1", 32'({sout1, busy1, done1, ready1, ovr1}), 32'(5'b10010));
    end

    // Single word 1011: 0,1,1,0,1,1(parity),1(stop).
    play0(9, 32'h1, 128'hB, s, d, b, o, ms);
    check("frame 1011 sout", s, 32'h1ED);
    check("frame 1011 model", ms, 32'h1ED);
    check("frame 1011 done", d, 32'h080);
    check("frame 1011 busy", b, 32'h0FE);

    // 3 then C two cycles later: no idle bit between frames.
    play0(16, 32'h5, 128'hC03, s, d, b, o, ms);
    check("b2b sout", s, 32'hD88D);
    check("b2b model", ms, 32'hD88D);
    check("b2b done", d, 32'h4080);
    check("b2b busy", b, 32'h7FFE);
    check("b2b overrun", o, 32'h0);

    // 1,2,3 on consecutive edges: word 2 meets a full holding register at
    // the load edge, so it is dropped; words 1 and 3 are sent.
    play0(16, 32'h7, 128'h321, s, d, b, o, ms);
    check("overrun sout", s, 32'hC6C5);
    check("overrun model", ms, 32'hC6C5);
    check("overrun flag", o, 32'hFFFE);
    for (int i = 0; i < 20; i++) step();
    check("overrun sticky", 32'(ovr0), 32'h1);
    rst = 1'b0;
    step();
    step();
    check("overrun cleared", 32'(ovr0), 32'h0);
    rst = 1'b1;

    // Reset during data bit 2 with a second word waiting.
    enb0 = 1'b1; c0 = 4'hA; step();
    enb0 = 1'b0; step();
    step();
    enb0 = 1'b1; c0 = 4'h5; step();
    check("hold full before reset", 32'(ready0), 32'h0);
    enb0 = 1'b0; step();
    check("data bit 2 level", 32'(sout0), 32'h0);
    rst = 1'b0; step();
    check("mid-frame reset", 32'({sout0, busy0, ready0, done0}), 32'(4'b1010));
    rst = 1'b1;
    play0(9, 32'h1, 128'h6, s, d, b, o, ms);
    check("clean frame after reset", s, 32'h199);

    // BIT_CYCLES=3, no parity, word 0001: 6 bits over 18 cycles.
    for (int i = 0; i < 20; i++) begin
      enb1 = (i == 0);
      c1   = 4'h1;
      step();
      s[i] = sout1; d[i] = done1; b[i] = busy1; ms[i] = m_sout[1];
    end
    enb1 = 1'b0;
    check("slow frame sout", s & 32'hFFFFF, 32'hF0071);
    check("slow frame model", ms & 32'hFFFFF, 32'hF0071);
    check("slow frame done", d & 32'hFFFFF, 32'h40000);
    check("slow frame busy", b & 32'hFFFFF, 32'h7FFFE);

    // Random traffic on both instances with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      enb0 = ($urandom_range(0, 3) == 0);
      c0   = 4'($urandom);
      enb1 = ($urandom_range(0, 9) == 0);
      c1   = 4'($urandom);
      rst  = ($urandom_range(0, 499) != 0);
      step();
    end
    enb0 = 1'b0;
    enb1 = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 30; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
